// File: rtl/img_frame_sequencer.sv
// -----------------------------------------------------------------------------
// img_frame_sequencer
//   Sequences one image capture onto the 12-bit dozen bus that feeds the JPEG
//   block.
//   - On capture_req in IDLE, it latches the 48-bit metadata
//     {compression, RGB, cam_id, timestamp, trigger_index}.
//   - It then forwards exactly PIXELS_PER_IMAGE pixel dozens.
//   - It then emits the metadata as 4 header dozens, MSB slice first.
//   - Both sides use valid/ready. The output side is a single register stage.
//
// Ports
//   sysClk, reset        : clock, synchronous active-high reset
//   capture_req          : start-of-image strobe (acted on in IDLE only)
//   compression, RGB,
//   cam_id, timestamp,
//   trigger_index        : metadata fields latched on an accepted capture_req
//   pix_data/pix_valid   : camera pixel stream
//   pix_ready            : pixel accepted this cycle (combinational)
//   dozen_out/_valid     : output register towards the JPEG block
//   dozen_out_ready      : JPEG block accepts dozen_out
//   busy                 : high outside IDLE
//   frame_done           : pulse on the handshake of the last header dozen
//   req_dropped          : pulse when capture_req is seen outside IDLE
// -----------------------------------------------------------------------------
module img_frame_sequencer #(
  parameter int unsigned PIXELS_PER_IMAGE = 307200,
  parameter int unsigned CNT_W            = 20
) (
  input  logic        sysClk,
  input  logic        reset,
  input  logic        capture_req,
  input  logic [1:0]  compression,
  input  logic        RGB,
  input  logic        cam_id,
  input  logic [27:0] timestamp,
  input  logic [15:0] trigger_index,
  input  logic [11:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [11:0] dozen_out,
  output logic        dozen_out_valid,
  input  logic        dozen_out_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        req_dropped
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PIXELS = 2'd1,
    ST_HEADER = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] PIX_TOTAL = CNT_W'(PIXELS_PER_IMAGE);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Header dozen idx 0..3 maps to metadata bits [47:36] down to [11:0].
  function automatic logic [11:0] hdr_slice(input logic [47:0] meta,
                                            input logic [1:0]  idx);
    logic [11:0] s;
    case (idx)
      2'd0:    s = meta[47:36];
      2'd1:    s = meta[35:24];
      2'd2:    s = meta[23:12];
      2'd3:    s = meta[11:0];
      default: s = 12'd0;
    endcase
    return s;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       hdr_idx_q, hdr_idx_d;
  logic [47:0]      meta_q, meta_d;
  logic [11:0]      dout_q, dout_d;
  logic             dvalid_q, dvalid_d;

  logic             out_free_s;
  logic             pix_ready_s;
  logic             frame_done_s;

  // The output stage can take a new dozen when empty or draining this cycle.
  assign out_free_s = !dvalid_q || dozen_out_ready;

  // Next-state, datapath loads and combinational strobes.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hdr_idx_d    = hdr_idx_q;
    meta_d       = meta_q;
    dout_d       = dout_q;
    // A free register with nothing loaded goes empty; a stalled one holds.
    dvalid_d     = out_free_s ? 1'b0 : dvalid_q;
    pix_ready_s  = 1'b0;
    frame_done_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (capture_req) begin
          meta_d    = {compression, RGB, cam_id, timestamp, trigger_index};
          cnt_d     = '0;
          hdr_idx_d = 2'd0;
          state_d   = ST_PIXELS;
        end else begin
          state_d   = ST_IDLE;
        end
      end

      ST_PIXELS: begin
        pix_ready_s = out_free_s;
        if (pix_valid && out_free_s) begin
          dout_d   = pix_data;
          dvalid_d = 1'b1;
          cnt_d    = cnt_q + CNT_ONE;
          // The transfer that brings the count up to the image size ends the pixel phase.
          if ((cnt_q + CNT_ONE) == PIX_TOTAL) begin
            state_d = ST_HEADER;
          end else begin
            state_d = ST_PIXELS;
          end
        end else begin
          state_d = ST_PIXELS;
        end
      end

      ST_HEADER: begin
        if (out_free_s) begin
          dout_d    = hdr_slice(meta_q, hdr_idx_q);
          dvalid_d  = 1'b1;
          hdr_idx_d = hdr_idx_q + 2'd1;
          if (hdr_idx_q == 2'd3) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_HEADER;
          end
        end else begin
          state_d = ST_HEADER;
        end
      end

      ST_DRAIN: begin
        // The register still holds header idx 3. Its handshake closes the frame.
        if (dvalid_q && dozen_out_ready) begin
          frame_done_s = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          state_d      = ST_DRAIN;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters, metadata and output register.
  always_ff @(posedge sysClk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hdr_idx_q <= 2'd0;
      meta_q    <= 48'd0;
      dout_q    <= 12'd0;
      dvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hdr_idx_q <= hdr_idx_d;
      meta_q    <= meta_d;
      dout_q    <= dout_d;
      dvalid_q  <= dvalid_d;
    end
  end

  assign pix_ready       = pix_ready_s;
  assign dozen_out       = dout_q;
  assign dozen_out_valid = dvalid_q;
  assign busy            = (state_q != ST_IDLE);
  assign frame_done      = frame_done_s;
  assign req_dropped     = capture_req && (state_q != ST_IDLE);

endmodule

// File: tb/tb_img_frame_sequencer.sv
// Scoreboard bench for img_frame_sequencer. Two instances are exercised:
//   - one with 4 pixels per image;
//   - one with 1 pixel per image.
// For each instance:
//   - a driver issues frames with randomized ready/valid patterns;
//   - a monitor derives every expected dozen from the frame's pixel list and
//     the 48-bit metadata, and pops and compares them on each output handshake.
module tb_img_frame_sequencer;

  logic sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input int inst, input bit ok, input string nm,
                     input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL inst%0d %s: got %0h expected %0h", inst, nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int N = (g == 0) ? 4 : 1;

    logic        reset, capture_req, rgb, cam_id, pix_valid, pix_ready;
    logic [1:0]  compression;
    logic [27:0] timestamp;
    logic [15:0] trig;
    logic [11:0] pix_data, dozen_out;
    logic        dozen_out_valid, dozen_out_ready, busy, frame_done, req_dropped;

    // Driver-owned bookkeeping.
    logic [11:0] pix_arr [4];
    bit          tp_mode  = 1'b0;
    bit          tmo      = 1'b0;
    bit          drv_done = 1'b0;

    // Monitor-owned bookkeeping.
    logic [12:0] exp_q [$];
    bit          model_busy = 1'b0;
    bit          fin        = 1'b0;

    img_frame_sequencer #(.PIXELS_PER_IMAGE(N), .CNT_W(20)) u_dut (
      .sysClk(sysClk), .reset(reset), .capture_req(capture_req),
      .compression(compression), .RGB(rgb), .cam_id(cam_id),
      .timestamp(timestamp), .trigger_index(trig),
      .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .dozen_out(dozen_out), .dozen_out_valid(dozen_out_valid),
      .dozen_out_ready(dozen_out_ready), .busy(busy),
      .frame_done(frame_done), .req_dropped(req_dropped)
    );

    task automatic rand_meta();
      compression = 2'($urandom);
      rgb         = 1'($urandom);
      cam_id      = 1'($urandom);
      timestamp   = 28'($urandom);
      trig        = 16'($urandom);
    endtask

    // rmode/vmode: 0 = always high, 1 = high one cycle in three, 2 = random.
    task automatic run_frame(input int rmode, input int vmode, input bit drop,
                             input int rst_at, input bit plan);
      int idx;
      int k;
      bit acc;
      for (int i = 0; i < N; i++) pix_arr[i] = 12'($urandom);
      if (plan) begin
        compression = 2'd2; rgb = 1'b1; cam_id = 1'b0;
        timestamp = 28'h1234567; trig = 16'hBEEF;
      end else begin
        rand_meta();
      end
      tp_mode = (rmode == 0) && (vmode == 0) && !drop && (rst_at == 0);
      capture_req = 1'b1;
      @(posedge sysClk); #1;
      capture_req = 1'b0;
      rand_meta();
      idx = 0;
      k = 0;
      while (model_busy && k < 400) begin
        if (rst_at != 0 && idx == rst_at) begin
          reset = 1'b1; pix_valid = 1'b0;
          @(posedge sysClk); #1;
          reset = 1'b0;
          break;
        end
        case (rmode)
          0:       dozen_out_ready = 1'b1;
          1:       dozen_out_ready = (k % 3 == 0);
          default: dozen_out_ready = 1'($urandom);
        endcase
        if (idx < N) begin
          case (vmode)
            0:       pix_valid = 1'b1;
            1:       pix_valid = (k % 3 == 0);
            default: pix_valid = 1'($urandom);
          endcase
        end else begin
          pix_valid = 1'b0;
        end
        pix_data    = pix_valid ? pix_arr[idx] : 12'($urandom);
        capture_req = drop && (k == 2);
        @(negedge sysClk);
        acc = pix_valid && pix_ready;
        @(posedge sysClk); #1;
        if (acc) idx++;
        k++;
      end
      if (k >= 400) tmo = 1'b1;
      capture_req = 1'b0; pix_valid = 1'b0; dozen_out_ready = 1'b1;
      repeat (2) begin @(posedge sysClk); #1; end
    endtask

    initial begin
      reset = 1'b1; capture_req = 1'b0; pix_valid = 1'b0; pix_data = 12'd0;
      dozen_out_ready = 1'b1;
      rand_meta();
      repeat (3) @(posedge sysClk);
      #1 reset = 1'b0;
      @(posedge sysClk); #1;
      run_frame(0, 0, 1'b0, 0, 1'b1);    // reference frame, full throughput
      run_frame(1, 0, 1'b0, 0, 1'b0);    // ready 1,0,0 pattern
      run_frame(0, 1, 1'b0, 0, 1'b0);    // pix_valid one cycle in three
      run_frame(2, 2, 1'b1, 0, 1'b0);    // request while busy is dropped
      if (N > 2) run_frame(0, 0, 1'b0, 2, 1'b0);  // reset after 2 pixels
      run_frame(0, 0, 1'b0, 0, 1'b0);    // fresh frame after the abort
      for (int f = 0; f < 6; f++) begin
        run_frame($urandom_range(0, 2), $urandom_range(0, 2), 1'b0, 0, 1'b0);
      end
      drv_done = 1'b1;
    end

    // Monitor and reference model.
    initial begin
      int          cyc;
      int          start_cyc;
      int          pix_left;
      bit          prev_reset;
      bit          prev_hold;
      logic [11:0] prev_val;
      bit          last;
      logic [12:0] e;
      logic [47:0] m;
      cyc = 0; start_cyc = 0; pix_left = 0;
      prev_reset = 1'b0; prev_hold = 1'b0; prev_val = 12'd0;
      forever begin
        @(negedge sysClk);
        cyc++;
        if (reset) begin
          exp_q.delete();
          model_busy = 1'b0;
          pix_left   = 0;
          prev_hold  = 1'b0;
          prev_reset = 1'b1;
        end else begin
          if (prev_reset) begin
            chk(g, dozen_out_valid == 1'b0, "reset_valid", 48'(dozen_out_valid), 48'd0);
            chk(g, busy == 1'b0, "reset_busy", 48'(busy), 48'd0);
            chk(g, frame_done == 1'b0, "reset_frame_done", 48'(frame_done), 48'd0);
          end
          if (prev_hold) begin
            chk(g, dozen_out_valid && (dozen_out == prev_val), "hold_stable",
                48'({dozen_out_valid, dozen_out}), 48'({1'b1, prev_val}));
          end
          chk(g, busy == model_busy, "busy", 48'(busy), 48'(model_busy));
          chk(g, req_dropped == (capture_req && model_busy), "req_dropped",
              48'(req_dropped), 48'(capture_req && model_busy));
          chk(g, pix_ready == (model_busy && pix_left > 0 && (!dozen_out_valid || dozen_out_ready)),
              "pix_ready", 48'(pix_ready),
              48'(model_busy && pix_left > 0 && (!dozen_out_valid || dozen_out_ready)));
          last = 1'b0;
          if (dozen_out_valid && dozen_out_ready) begin
            chk(g, exp_q.size() != 0, "unexpected_dozen", 48'(dozen_out), 48'd0);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              chk(g, dozen_out == e[11:0], "dozen", 48'(dozen_out), 48'(e[11:0]));
              last = e[12];
            end
          end
          chk(g, frame_done == last, "frame_done", 48'(frame_done), 48'(last));
          if (last && tp_mode) begin
            chk(g, (cyc - start_cyc) == N + 5, "frame_cycles",
                48'(cyc - start_cyc), 48'(N + 5));
          end
          if (pix_valid && pix_ready && pix_left > 0) pix_left--;
          if (!model_busy && capture_req) begin
            model_busy = 1'b1;
            start_cyc  = cyc;
            pix_left   = N;
            m = {compression, rgb, cam_id, timestamp, trig};
            for (int i = 0; i < N; i++) exp_q.push_back({1'b0, pix_arr[i]});
            for (int i = 0; i < 4; i++) begin
              exp_q.push_back({(i == 3), 12'((m >> (36 - 12 * i)) & 48'hFFF)});
            end
          end else if (last) begin
            model_busy = 1'b0;
          end
          prev_hold  = dozen_out_valid && !dozen_out_ready;
          prev_val   = dozen_out;
          prev_reset = 1'b0;
          if (drv_done && !fin) begin
            chk(g, !tmo, "frame_timeout", 48'(tmo), 48'd0);
            chk(g, exp_q.size() == 0, "leftover_dozens", 48'(exp_q.size()), 48'd0);
            fin = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    for (int t = 0; t < 20000; t++) begin
      @(posedge sysClk);
      if (g_inst[0].fin && g_inst[1].fin) break;
    end
    if (!(g_inst[0].fin && g_inst[1].fin)) begin
      $display("FAIL watchdog: got unfinished expected finished");
      $fatal(1, "watchdog expired");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
